// File: rtl/simple_mac_rx.sv
// simple_mac_rx: MII receive MAC stripping preamble/FCS, checking CRC/length, streaming bytes out
module simple_mac_rx #(
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1518
) (
  input  logic        eth_rxclk,
  input  logic        rst,
  input  logic        eth_rxdv,
  input  logic [3:0]  eth_rxd,
  input  logic        eth_rxer,
  output logic [7:0]  rx_tdata,
  output logic        rx_tvalid,
  output logic        rx_tlast,
  output logic        rx_tuser,
  output logic [15:0] frame_cnt,
  output logic [15:0] err_cnt
);
  typedef enum logic [1:0] {IDLE, PRE, DATA, DROP} state_t;
  localparam logic [15:0] MIN_L = 16'(MIN_LEN);
  localparam logic [15:0] MAX_L = 16'(MAX_LEN);
  localparam logic [31:0] RESIDUE = 32'hDEBB20E3;
  state_t state, state_nxt;
  logic phase, rxer_seen, sfd, byte_done, eof, bad;
  logic [3:0] lo_nib;
  logic [7:0] new_byte;
  logic [15:0] byte_cnt;
  logic [31:0] crc, crc_nxt;
  logic [4:0][7:0] pipe;
  logic [4:0] pipe_vld;
  function automatic logic [31:0] crc8(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int i = 0; i < 8; i++) r = r[0] ? (r >> 1) ^ 32'hEDB88320 : r >> 1;
    return r;
  endfunction
  // state register; reset lands in DROP so an interrupted frame is discarded
  always_ff @(posedge eth_rxclk) state <= rst ? DROP : state_nxt;
  // next state and per-cycle control strobes
  always_comb begin
    state_nxt = state;
    sfd = 1'b0;
    byte_done = 1'b0;
    eof = 1'b0;
    case (state)
      IDLE: if (eth_rxdv) state_nxt = (eth_rxd == 4'h5) ? PRE : DROP;
      PRE: begin
        if (!eth_rxdv) state_nxt = IDLE;
        else if (eth_rxd == 4'hD) begin
          state_nxt = DATA;
          sfd = 1'b1;
        end else if (eth_rxd != 4'h5) state_nxt = DROP;
      end
      DATA: begin
        if (!eth_rxdv) begin
          state_nxt = IDLE;
          eof = 1'b1;
        end else byte_done = phase;
      end
      default: if (!eth_rxdv) state_nxt = IDLE;
    endcase
  end
  assign new_byte = {eth_rxd, lo_nib};
  assign crc_nxt = crc8(crc, new_byte);
  assign bad = (crc != RESIDUE) || phase || rxer_seen || (byte_cnt < MIN_L) || (byte_cnt > MAX_L);
  // byte assembly, CRC, FCS hold pipe, beat generation and frame counters
  always_ff @(posedge eth_rxclk) begin
    if (rst) begin
      phase <= 1'b0;
      rxer_seen <= 1'b0;
      lo_nib <= '0;
      byte_cnt <= '0;
      crc <= 32'hFFFFFFFF;
      pipe <= '0;
      pipe_vld <= '0;
      rx_tdata <= '0;
      rx_tvalid <= 1'b0;
      rx_tlast <= 1'b0;
      rx_tuser <= 1'b0;
      frame_cnt <= '0;
      err_cnt <= '0;
    end else begin
      rx_tvalid <= 1'b0;
      rx_tlast <= 1'b0;
      rx_tuser <= 1'b0;
      if (sfd) begin
        phase <= 1'b0;
        rxer_seen <= 1'b0;
        byte_cnt <= '0;
        crc <= 32'hFFFFFFFF;
        pipe_vld <= '0;
      end
      if (state == DATA && eth_rxdv) begin
        phase <= ~phase;
        rxer_seen <= rxer_seen | eth_rxer;
        if (!phase) lo_nib <= eth_rxd;
        if (byte_done) begin
          crc <= crc_nxt;
          byte_cnt <= (byte_cnt == 16'hFFFF) ? byte_cnt : byte_cnt + 16'd1;
          pipe <= {pipe[3:0], new_byte};
          pipe_vld <= {pipe_vld[3:0], 1'b1};
          if (pipe_vld[4]) begin
            rx_tvalid <= 1'b1;
            rx_tdata <= pipe[4];
          end
        end
      end
      if (eof) begin
        if (pipe_vld[4]) begin
          rx_tvalid <= 1'b1;
          rx_tlast <= 1'b1;
          rx_tuser <= bad;
          rx_tdata <= pipe[4];
        end
        if (pipe_vld[4] && !bad) frame_cnt <= frame_cnt + 16'd1;
        else err_cnt <= err_cnt + 16'd1;
      end
    end
  end
endmodule

// File: tb/tb_simple_mac_rx.sv
// tb_simple_mac_rx: directed frame-level checks of the MII receive MAC
module tb_simple_mac_rx;
  logic eth_rxclk = 1'b0;
  logic rst = 1'b1;
  logic eth_rxdv = 1'b0;
  logic [3:0] eth_rxd = '0;
  logic eth_rxer = 1'b0;
  logic [7:0] rx_tdata;
  logic rx_tvalid, rx_tlast, rx_tuser;
  logic [15:0] frame_cnt, err_cnt;
  int checks = 0;
  int errors = 0;
  int beats = 0;
  int lasts = 0;
  int data_bad = 0;
  int idx = 0;
  int rst_snap = 0;
  int b0, l0;
  logic last_user = 1'b0;
  logic [7:0] last_data = '0;
  logic [3:0] nq[$];
  simple_mac_rx dut (
    .eth_rxclk(eth_rxclk), .rst(rst), .eth_rxdv(eth_rxdv), .eth_rxd(eth_rxd), .eth_rxer(eth_rxer),
    .rx_tdata(rx_tdata), .rx_tvalid(rx_tvalid), .rx_tlast(rx_tlast), .rx_tuser(rx_tuser),
    .frame_cnt(frame_cnt), .err_cnt(err_cnt)
  );
  always #20 eth_rxclk = ~eth_rxclk;
  // every frame payload is 0,1,2,...; beats are checked against that running index
  always @(negedge eth_rxclk) begin
    if (rst) idx = 0;
    else if (rx_tvalid) begin
      beats++;
      if (rx_tdata !== idx[7:0]) data_bad++;
      if (rx_tlast) begin
        lasts++;
        last_user = rx_tuser;
        last_data = rx_tdata;
        idx = 0;
      end else idx++;
    end
  end
  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c ^ {24'h0, d};
    for (int k = 0; k < 8; k++) r = r[0] ? (r >> 1) ^ 32'hEDB88320 : r >> 1;
    return r;
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic add_byte(input logic [7:0] b);
    nq.push_back(b[3:0]);
    nq.push_back(b[7:4]);
  endtask
  task automatic add_pre();
    for (int k = 0; k < 7; k++) add_byte(8'h55);
    add_byte(8'hD5);
  endtask
  task automatic add_frame(input int n, input logic flip);
    logic [31:0] c;
    logic [31:0] fcs;
    c = 32'hFFFFFFFF;
    add_pre();
    for (int k = 0; k < n; k++) begin
      add_byte(k[7:0]);
      c = crc_upd(c, k[7:0]);
    end
    fcs = ~c ^ {31'h0, flip};
    for (int k = 0; k < 4; k++) add_byte(fcs[8*k +: 8]);
  endtask
  task automatic drive(input int rxer_at, input int rst_at);
    for (int k = 0; k < nq.size(); k++) begin
      @(negedge eth_rxclk);
      eth_rxdv = 1'b1;
      eth_rxd = nq[k];
      eth_rxer = (k == rxer_at);
      rst = (k == rst_at) || (k == rst_at + 1);
      if (k == rst_at + 2) rst_snap = beats;
    end
    @(negedge eth_rxclk);
    eth_rxdv = 1'b0;
    eth_rxd = '0;
    eth_rxer = 1'b0;
    rst = 1'b0;
    repeat (23) @(negedge eth_rxclk);
    nq.delete();
  endtask
  task automatic do_reset();
    @(negedge eth_rxclk);
    rst = 1'b1;
    repeat (2) @(negedge eth_rxclk);
    rst = 1'b0;
    repeat (2) @(negedge eth_rxclk);
    b0 = beats;
    l0 = lasts;
  endtask
  initial begin
    repeat (3) @(negedge eth_rxclk);
    chk("reset_tvalid", {31'h0, rx_tvalid}, 32'h0);
    chk("reset_tdata", {24'h0, rx_tdata}, 32'h0);
    chk("reset_frame_cnt", {16'h0, frame_cnt}, 32'h0);
    chk("reset_err_cnt", {16'h0, err_cnt}, 32'h0);
    do_reset();
    add_frame(60, 1'b0);
    drive(-10, -10);
    chk("good_beats", beats - b0, 60);
    chk("good_lasts", lasts - l0, 1);
    chk("good_last_data", {24'h0, last_data}, 32'h3B);
    chk("good_tuser", {31'h0, last_user}, 32'h0);
    chk("good_frame_cnt", {16'h0, frame_cnt}, 32'd1);
    chk("good_err_cnt", {16'h0, err_cnt}, 32'd0);
    chk("good_data", data_bad, 0);
    do_reset();
    add_frame(60, 1'b1);
    drive(-10, -10);
    chk("fcs_beats", beats - b0, 60);
    chk("fcs_tuser", {31'h0, last_user}, 32'h1);
    chk("fcs_err_cnt", {16'h0, err_cnt}, 32'd1);
    chk("fcs_frame_cnt", {16'h0, frame_cnt}, 32'd0);
    do_reset();
    add_frame(60, 1'b0);
    drive(76, -10);
    chk("rxer_beats", beats - b0, 60);
    chk("rxer_tuser", {31'h0, last_user}, 32'h1);
    chk("rxer_err_cnt", {16'h0, err_cnt}, 32'd1);
    do_reset();
    add_frame(60, 1'b0);
    nq.push_back(4'h0);
    drive(-10, -10);
    chk("odd_beats", beats - b0, 60);
    chk("odd_tuser", {31'h0, last_user}, 32'h1);
    chk("odd_err_cnt", {16'h0, err_cnt}, 32'd1);
    do_reset();
    add_pre();
    for (int k = 0; k < 3; k++) add_byte(k[7:0]);
    drive(-10, -10);
    chk("short_beats", beats - b0, 0);
    chk("short_err_cnt", {16'h0, err_cnt}, 32'd1);
    chk("short_frame_cnt", {16'h0, frame_cnt}, 32'd0);
    do_reset();
    add_frame(36, 1'b0);
    drive(-10, -10);
    chk("runt_beats", beats - b0, 36);
    chk("runt_last_data", {24'h0, last_data}, 32'h23);
    chk("runt_tuser", {31'h0, last_user}, 32'h1);
    chk("runt_err_cnt", {16'h0, err_cnt}, 32'd1);
    do_reset();
    add_frame(60, 1'b0);
    drive(-10, 56);
    chk("rst_no_beats", beats, rst_snap);
    chk("rst_frame_cnt", {16'h0, frame_cnt}, 32'd0);
    chk("rst_err_cnt", {16'h0, err_cnt}, 32'd0);
    b0 = beats;
    add_frame(60, 1'b0);
    drive(-10, -10);
    chk("after_rst_beats", beats - b0, 60);
    chk("after_rst_frame_cnt", {16'h0, frame_cnt}, 32'd1);
    do_reset();
    nq.push_back(4'h5);
    nq.push_back(4'h5);
    nq.push_back(4'hA);
    add_frame(60, 1'b0);
    drive(-10, -10);
    chk("badpre_beats", beats - b0, 0);
    chk("badpre_frame_cnt", {16'h0, frame_cnt}, 32'd0);
    chk("badpre_err_cnt", {16'h0, err_cnt}, 32'd0);
    do_reset();
    add_frame(60, 1'b0);
    drive(-10, -10);
    add_frame(60, 1'b0);
    drive(-10, -10);
    chk("b2b_lasts", lasts - l0, 2);
    chk("b2b_beats", beats - b0, 120);
    chk("b2b_frame_cnt", {16'h0, frame_cnt}, 32'd2);
    chk("b2b_err_cnt", {16'h0, err_cnt}, 32'd0);
    chk("all_data", data_bad, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
